// File: rtl/ieee_fixed_pkg.sv
// Shared IEEE-754 single-precision field constants, operand classes and
// rounding-mode encodings for the float-to-fixed converter.
package ieee_fixed_pkg;

    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic RM_TRUNC = 1'b0;
    localparam logic RM_RNE   = 1'b1;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } cls_t;

    function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0)
            return (m == '0) ? CLS_ZERO : CLS_DENORM;
        else if (e == '1)
            return (m == '0) ? CLS_INF : CLS_NAN;
        else
            return CLS_NORMAL;
    endfunction

endpackage

// File: rtl/fp_shift_round.sv
// Combinational stage-2 core: aligns {1,man} to the fixed-point grid, derives
// guard/sticky, applies rounding and saturation, and resolves special classes.
module fp_shift_round
    import ieee_fixed_pkg::*;
#(
    parameter int INT_W  = 5,
    parameter int FRAC_W = 5
) (
    input  logic               sign,
    input  logic signed [8:0]  p,
    input  logic [MAN_W:0]     mant,
    input  logic               round_mode,
    input  cls_t               cls,
    output logic [INT_W-1:0]   res_digit,
    output logic [FRAC_W-1:0]  res_float,
    output logic               res_sign,
    output logic               ovf,
    output logic               unf,
    output logic               inv
);

    localparam int W     = INT_W + FRAC_W;
    localparam int FRAME = 64;

    // The mantissa sits at the top of a 2*FRAME window; after the right shift
    // the upper half is the integer magnitude and the lower half feeds guard/sticky.
    logic [2*FRAME-1:0] frame;
    logic [FRAME-1:0]   whole;
    logic [6:0]         shamt;
    logic               guard;
    logic               sticky;
    logic               inc;
    logic               too_big;
    logic [W:0]         sum;
    logic               unused_bits;
    int                 s;

    always_comb begin
        s = FRAME - 1 - FRAC_W - int'(p);
        if (s > 2*FRAME - 1)
            s = 2*FRAME - 1;
        shamt   = 7'(s);
        frame   = {mant, {(2*FRAME-MAN_W-1){1'b0}}} >> shamt;
        whole   = frame[2*FRAME-1:FRAME];
        guard   = frame[FRAME-1];
        sticky  = |frame[FRAME-2:0];
        inc     = (round_mode == RM_RNE) & guard & (sticky | whole[0]);
        sum     = {1'b0, whole[W-1:0]} + {{W{1'b0}}, inc};
        too_big = int'(p) >= INT_W;
    end

    assign unused_bits = |whole[FRAME-1:W];

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        {res_digit, res_float} = '0;
        res_sign = sign;
        ovf      = 1'b0;
        unf      = 1'b0;
        inv      = 1'b0;
        unique case (cls)
            CLS_ZERO: ;
            CLS_DENORM: unf = 1'b1;
            CLS_INF: begin
                {res_digit, res_float} = '1;
                ovf = 1'b1;
            end
            CLS_NAN: begin
                res_sign = 1'b0;
                inv      = 1'b1;
            end
            default: begin
                if (too_big || sum[W]) begin
                    {res_digit, res_float} = '1;
                    ovf = 1'b1;
                end else begin
                    {res_digit, res_float} = sum[W-1:0];
                    unf = (sum[W-1:0] == '0);
                end
            end
        endcase
    end

endmodule

// File: rtl/ieee_to_fixed_pipe.sv
// Two-stage IEEE-754 single to sign-magnitude fixed-point converter with
// valid/ready handshakes on both sides; stage 1 decodes, stage 2 drives outputs.
module ieee_to_fixed_pipe
    import ieee_fixed_pkg::*;
#(
    parameter int INT_W  = 5,
    parameter int FRAC_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in,
    input  logic              round_mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [INT_W-1:0]  out_digit,
    output logic [FRAC_W-1:0] out_float,
    output logic              out_sign,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_inv,
    output logic              out_valid,
    input  logic              out_ready
);

    logic              s1_valid;
    logic              s1_sign;
    logic signed [8:0] s1_p;
    logic [MAN_W:0]    s1_mant;
    logic              s1_rm;
    cls_t              s1_cls;

    logic              s2_load;
    logic              accept;

    logic [INT_W-1:0]  res_digit;
    logic [FRAC_W-1:0] res_float;
    logic              res_sign;
    logic              res_ovf;
    logic              res_unf;
    logic              res_inv;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s1_valid <= 1'b0;
        else if (in_ready)
            s1_valid <= in_valid;
    end

    // NOTE: stage-1 payload is qualified by s1_valid, so it is left unreset;
    // only control and the visible outputs need a defined reset value.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_sign <= in[31];
            s1_p    <= 9'($signed({1'b0, in[30:23]}) - BIAS);
            s1_mant <= {1'b1, in[MAN_W-1:0]};
            s1_rm   <= round_mode;
            s1_cls  <= classify(in[30:23], in[MAN_W-1:0]);
        end
    end

    fp_shift_round #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .sign       (s1_sign),
        .p          (s1_p),
        .mant       (s1_mant),
        .round_mode (s1_rm),
        .cls        (s1_cls),
        .res_digit  (res_digit),
        .res_float  (res_float),
        .res_sign   (res_sign),
        .ovf        (res_ovf),
        .unf        (res_unf),
        .inv        (res_inv)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_digit <= '0;
            out_float <= '0;
            out_sign  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_inv   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_digit <= res_digit;
                out_float <= res_float;
                out_sign  <= res_sign;
                out_ovf   <= res_ovf;
                out_unf   <= res_unf;
                out_inv   <= res_inv;
            end
        end
    end

endmodule

// File: doc/ieee_to_fixed_pipe.md
Name: ieee_to_fixed_pipe

Overview:
- Pipelined converter from IEEE-754 single precision to sign-magnitude fixed point, with parametrised integer and fraction widths.
- Adds what the combinational converter lacks:
  - full exponent range
  - sign, zero, denormal, Inf and NaN handling
  - selectable rounding
  - saturation with status flags
  - valid/ready handshakes
- Sits between the float operand source and the fixed-point ALU datapath.

Parameters:
- INT_W, 5, integer-part width of out_digit; legal range 1..16.
- FRAC_W, 5, fraction width of out_float; legal range 1..16, with INT_W+FRAC_W <= 32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  32  IEEE-754 single operand.
- round_mode  input  1  0 = truncate toward zero, 1 = round-to-nearest-even; sampled with in.
- in_valid  input  1  operand present.
- in_ready  output  1  converter accepts operand this cycle.
- out_digit  output  INT_W  integer part of magnitude.
- out_float  output  FRAC_W  fraction part of magnitude.
- out_sign  output  1  sign of result.
- out_ovf  output  1  result saturated (magnitude too large, or Inf).
- out_unf  output  1  nonzero input produced zero magnitude.
- out_inv  output  1  input was NaN.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.

Behaviour:
- Reset (async, active-high):
  - Both stage-valid bits clear.
  - All outputs go to 0, except in_ready, which is 1 once both stages are empty.
- Pipeline:
  - Stage 1 (decode) registers sign, exponent, {1,mantissa}, round_mode and class.
  - Stage 2 (shift/round/saturate) drives the output registers directly.
  - Latency is 2 cycles from accept to out_valid when out_ready=1.
  - Throughput is 1 result per cycle.
- Handshake:
  - Accept on in_valid & in_ready. Deliver on out_valid & out_ready.
  - Stage 2 loads when it is empty or its result is being delivered this cycle.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid | s2_load (combinational from out_ready; no skid buffer).
  - out_* stay stable while out_valid & !out_ready.
  - Accept and deliver in the same cycle is legal with a full pipeline.
- Classes (exp = in[30:23], man = in[22:0]):
  - exp=0, man=0: result 0; no flags.
  - exp=0, man!=0 (denormal): result 0; out_unf=1.
  - exp=255, man=0 (Inf): saturate; out_ovf=1.
  - exp=255, man!=0 (NaN): result 0; out_sign=0; out_inv=1.
  - Otherwise normal: p = exp-127, signed 9-bit.
- Normal conversion:
  - Magnitude M = {1,man} * 2^(p-23+FRAC_W), built as an (INT_W+FRAC_W+1)-bit value plus guard and sticky bits.
  - Shift is right when p-23+FRAC_W < 0; bits shifted out feed guard/sticky.
  - Truncate: drop guard/sticky.
  - RNE: increment if guard & (sticky | lsb).
- Saturation and underflow:
  - p >= INT_W, or a rounding carry into bit INT_W+FRAC_W: out_digit and out_float all ones; out_ovf=1.
  - Normal input whose final magnitude is 0: out_unf=1.
- out_sign = in[31] for every class except NaN. -0 gives out_sign=1 with zero magnitude.
- out_ovf, out_unf and out_inv are mutually exclusive.

Decomposition:
- Package ieee_fixed_pkg holds:
  - constants BIAS=127, EXP_W=8, MAN_W=23
  - class enum {ZERO, DENORM, NORMAL, INF, NAN}
  - round-mode constants
- One sub-module, fp_shift_round:
  - combinational stage-2 core
  - computes shift, guard/sticky, rounding and saturation from sign, p, {1,man} and round_mode
  - instantiated between the stage-1 and stage-2 registers.

Test Plan (default INT_W=5, FRAC_W=5):
- 0x3F800000, RNE -> digit 00001, float 00000, sign 0, no flags; out_valid exactly 2 cycles after accept.
- 0x40B00000 (5.5) -> 00101 / 10000. 0xC0B00000 -> same magnitude, out_sign=1.
- 0x3F860000 (1.046875):
  - truncate -> 00001 / 00001
  - RNE -> 00001 / 00010 (tie to even)
- 0x42000000 (32.0) and 0x7F800000 (Inf) -> 11111 / 11111 with out_ovf=1. 0x7FC00000 -> zero magnitude, out_sign=0, out_inv=1.
- 0x3C800000 (2^-6):
  - RNE -> zero magnitude with out_unf=1
  - 0x00000001 -> zero magnitude with out_unf=1
  - 0x00000000 -> zero magnitude, no flags
- Backpressure and reset:
  - Stream 4 operands with out_ready low for 3 cycles: in_ready drops after 2 accepts, outputs hold stable, all 4 results arrive in order.
  - Assert reset mid-stream: out_valid=0 immediately; no stale result after release.
